cpu6_trap_ctrl: RTL

//   Machine-mode trap/return controller for cpu6, next to the E stage of the datapath. Takes
//   E-stage illegal-instruction, ecall and mret events. Owns the trap CSRs:

---
 rtl/cpu6_trap_ctrl_pkg.sv | 34 +++
 rtl/cpu6_trap_fsm.sv | 58 +++++
 rtl/cpu6_trap_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared constants and types for the cpu6 machine-mode trap/return controller.
package cpu6_trap_ctrl_pkg;

   localparam int unsigned CPU6_XLEN = 32;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;

   localparam int unsigned MCAUSE_ILLEGAL = 2;
   localparam int unsigned MCAUSE_ECALL   = 11;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;

   localparam int unsigned DRAIN_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REDIR = 2'd1,
      ST_DRAIN = 2'd2
   } trap_state_e;

   // Qualified, mutually exclusive E-stage actions for one cycle.
   typedef struct packed {
      logic trap;
      logic is_illegal;
      logic mret;
      logic csr_wr;
   } trap_evt_t;

endpackage

// File: rtl/cpu6_trap_fsm.sv
// Redirect/flush sequencer: one redirect cycle followed by a counted drain window.
module cpu6_trap_fsm
   import cpu6_trap_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_event,
   output logic o_idle_c,
   output logic o_redirect_valid,
   output logic o_flush
);

   trap_state_e              r_state;
   logic [DRAIN_CNT_W-1:0]   r_cnt;

   assign o_idle_c = (r_state == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_cnt            <= '0;
         o_redirect_valid <= 1'b0;
         o_flush          <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_event) begin
                  r_state          <= ST_REDIR;
                  o_redirect_valid <= 1'b1;
                  o_flush          <= 1'b1;
               end
            end
            ST_REDIR: begin
               r_state          <= ST_DRAIN;
               r_cnt            <= DRAIN_CNT_W'(FLUSH_CYCLES);
               o_redirect_valid <= 1'b0;
               o_flush          <= 1'b1;
            end
            ST_DRAIN: begin
               r_cnt <= r_cnt - DRAIN_CNT_W'(1);
               // Last drain cycle: leave flush low for the first IDLE cycle.
               if (r_cnt == DRAIN_CNT_W'(1)) begin
                  r_state <= ST_IDLE;
                  o_flush <= 1'b0;
               end
            end
            default: begin
               r_state          <= ST_IDLE;
               o_redirect_valid <= 1'b0;
               o_flush          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// Machine-mode trap/return controller: owns trap CSRs and drives the PC redirect and flush.
module cpu6_trap_ctrl
   import cpu6_trap_ctrl_pkg::*;
#(
   parameter int unsigned       XLEN         = CPU6_XLEN,
   parameter logic [XLEN-1:0]   RESET_MTVEC  = XLEN'(32'h0000_0040),
   parameter int unsigned       FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic            excp_illinstr_e,
   input  logic            ecall_e,
   input  logic            mret_e,
   input  logic            csr_we_e,
   input  logic [11:0]     csr_addr_e,
   input  logic [XLEN-1:0] csr_wdata_e,
   output logic [XLEN-1:0] csr_rdata,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mcause,
   output logic            mstatus_mie
);

   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [XLEN-1:0] r_redirect_pc;
   logic [XLEN-1:0] w_mstatus;
   logic            w_idle;
   trap_evt_t       w_evt;

   // Only a real instruction in IDLE acts; trap beats mret beats CSR write.
   always_comb begin
      w_evt            = '0;
      w_evt.trap       = valid_e & w_idle & (excp_illinstr_e | ecall_e);
      w_evt.is_illegal = excp_illinstr_e;
      w_evt.mret       = valid_e & w_idle & mret_e & ~w_evt.trap;
      w_evt.csr_wr     = valid_e & w_idle & csr_we_e & ~w_evt.trap & ~mret_e;
   end

   cpu6_trap_fsm #(
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) u_fsm (
      .clk              (clk),
      .reset            (reset),
      .i_event          (w_evt.trap | w_evt.mret),
      .o_idle_c         (w_idle),
      .o_redirect_valid (redirect_valid),
      .o_flush          (flush)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mie         <= 1'b0;
         r_mpie        <= 1'b0;
         r_mtvec       <= RESET_MTVEC;
         r_mscratch    <= '0;
         r_mepc        <= '0;
         r_mcause      <= '0;
         r_redirect_pc <= '0;
      end else if (w_evt.trap) begin
         r_mepc        <= pc_e & ~XLEN'(3);
         r_mcause      <= w_evt.is_illegal ? XLEN'(MCAUSE_ILLEGAL) : XLEN'(MCAUSE_ECALL);
         r_mpie        <= r_mie;
         r_mie         <= 1'b0;
         r_redirect_pc <= r_mtvec & ~XLEN'(3);
      end else if (w_evt.mret) begin
         r_redirect_pc <= r_mepc;
         r_mie         <= r_mpie;
         r_mpie        <= 1'b1;
      end else if (w_evt.csr_wr) begin
         case (csr_addr_e)
            CSR_MSTATUS: begin
               r_mie  <= csr_wdata_e[MSTATUS_MIE_BIT];
               r_mpie <= csr_wdata_e[MSTATUS_MPIE_BIT];
            end
            CSR_MTVEC:    r_mtvec    <= csr_wdata_e & ~XLEN'(3);
            CSR_MSCRATCH: r_mscratch <= csr_wdata_e;
            CSR_MEPC:     r_mepc     <= csr_wdata_e & ~XLEN'(3);
            CSR_MCAUSE:   r_mcause   <= csr_wdata_e;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_mstatus                   = '0;
      w_mstatus[MSTATUS_MIE_BIT]  = r_mie;
      w_mstatus[MSTATUS_MPIE_BIT] = r_mpie;
      case (csr_addr_e)
         CSR_MSTATUS:  csr_rdata = w_mstatus;
         CSR_MTVEC:    csr_rdata = r_mtvec;
         CSR_MSCRATCH: csr_rdata = r_mscratch;
         CSR_MEPC:     csr_rdata = r_mepc;
         CSR_MCAUSE:   csr_rdata = r_mcause;
         default:      csr_rdata = '0;
      endcase
   end

   assign redirect_pc = r_redirect_pc;
   assign mepc        = r_mepc;
   assign mtvec       = r_mtvec;
   assign mcause      = r_mcause;
   assign mstatus_mie = r_mie;

endmodule
